// File: rtl/vga_tile_grid.sv
// Keyboard-driven VGA tile painter: ROWSxCOLS colour grid with cursor, paint, clear and ring rotation.
// Optional build macro TILE_CURSOR_EN adds an inverted 2-pixel frame around the cursor tile.
module vga_tile_grid #(
  parameter int unsigned COLS     = 3,
  parameter int unsigned ROWS     = 3,
  parameter int unsigned CW       = 3,
  parameter int unsigned H_START  = 160,
  parameter int unsigned V_START  = 48,
  parameter int unsigned TILE_W   = 213,
  parameter int unsigned TILE_H   = 134,
  parameter int unsigned LOOP_DIV = 5499999
) (
  input  logic                          clk25,
  input  logic                          reset,
  input  logic [9:0]                    HcntValue,
  input  logic [8:0]                    VcntValue,
  input  logic [7:0]                    scancode,
  input  logic                          found,
  output logic                          hsync,
  output logic                          vsync,
  output logic [CW-1:0]                 red,
  output logic [CW-1:0]                 green,
  output logic [CW-1:0]                 blue,
  output logic [$clog2(ROWS*COLS)-1:0]  cursor,
  output logic                          loop_active
);

  localparam int unsigned NT       = ROWS * COLS;
  localparam int unsigned TW       = $clog2(NT);
  localparam int unsigned RWD      = $clog2(ROWS);
  localparam int unsigned CWD      = $clog2(COLS);
  localparam int unsigned PW       = 3 * CW;
  localparam int unsigned RING_LEN = 2 * (ROWS + COLS) - 4;
  localparam int unsigned DW       = (LOOP_DIV > 0) ? $clog2(LOOP_DIV + 1) : 1;
  localparam int unsigned ACT_W    = 640;
  localparam int unsigned ACT_H    = 400;

  localparam logic [7:0] K_UP = 8'h1D, K_LEFT = 8'h1C, K_DOWN = 8'h1B, K_RIGHT = 8'h23;
  localparam logic [7:0] K_RED = 8'h2D, K_GREEN = 8'h34, K_BLUE = 8'h32, K_CYAN = 8'h21;
  localparam logic [7:0] K_WHITE = 8'h2B, K_BLACK = 8'h22, K_CLEAR = 8'h15;
  localparam logic [7:0] K_LOOP_CW = 8'h4B, K_LOOP_CCW = 8'h42, K_STOP = 8'h4D;

  localparam logic [CW-1:0] FULL = '1;
  localparam logic [CW-1:0] ZERO = '0;

  typedef enum logic [1:0] {S_IDLE, S_CW, S_CCW} loop_state_e;
  typedef logic [PW-1:0] colour_t;

  colour_t           tiles_q [NT];
  colour_t           tiles_d [NT];
  logic [RWD-1:0]    row_q, row_d;
  logic [CWD-1:0]    col_q, col_d;
  logic [TW-1:0]     cursor_q, cursor_d;
  loop_state_e       state_q, state_d;
  logic [DW-1:0]     div_q, div_d;
  logic              loop_active_q;
  logic              hsync_q, hsync_d, vsync_q, vsync_d;
  colour_t           rgb_q, rgb_d;
  logic              key_hit, tick;

  int unsigned       hx, vy, pc, pr;
  logic              in_win;
  colour_t           pix;
`ifdef TILE_CURSOR_EN
  int unsigned       lx, ly;
`endif

  // Tile index of ring position k, clockwise from tile 0.
  function automatic int unsigned ring_tile(input int unsigned k);
    if (k < COLS)                         return k;
    else if (k < COLS + ROWS - 1)         return (k - COLS + 1) * COLS + (COLS - 1);
    else if (k < 2 * COLS + ROWS - 2)     return (ROWS - 1) * COLS + (COLS - 2 - (k - (COLS + ROWS - 1)));
    else                                  return (ROWS - 2 - (k - (2 * COLS + ROWS - 2))) * COLS;
  endfunction

  // Key decode, loop FSM, divider and ring rotation; a key always beats a same-cycle step.
  always_comb begin
    tiles_d = tiles_q;
    row_d   = row_q;
    col_d   = col_q;
    state_d = state_q;
    div_d   = div_q;
    key_hit = 1'b0;
    tick    = (state_q != S_IDLE) && (div_q == DW'(LOOP_DIV));

    if (found) begin
      key_hit = 1'b1;
      case (scancode)
        K_UP:       if (row_q != '0) row_d = row_q - RWD'(1);
        K_DOWN:     if (row_q != RWD'(ROWS - 1)) row_d = row_q + RWD'(1);
        K_LEFT:     if (col_q != '0) col_d = col_q - CWD'(1);
        K_RIGHT:    if (col_q != CWD'(COLS - 1)) col_d = col_q + CWD'(1);
        K_RED:      tiles_d[cursor_q] = {FULL, ZERO, ZERO};
        K_GREEN:    tiles_d[cursor_q] = {ZERO, FULL, ZERO};
        K_BLUE:     tiles_d[cursor_q] = {ZERO, ZERO, FULL};
        K_CYAN:     tiles_d[cursor_q] = {ZERO, FULL, FULL};
        K_WHITE:    tiles_d[cursor_q] = {FULL, FULL, FULL};
        K_BLACK:    tiles_d[cursor_q] = '0;
        K_CLEAR: begin
          for (int unsigned i = 0; i < NT; i++) tiles_d[i] = '0;
          row_d   = '0;
          col_d   = '0;
          state_d = S_IDLE;
        end
        K_LOOP_CW:  state_d = S_CW;
        K_LOOP_CCW: state_d = S_CCW;
        K_STOP:     state_d = S_IDLE;
        default:    key_hit = 1'b0;
      endcase
    end

    if (tick && !key_hit) begin
      for (int unsigned k = 0; k < RING_LEN; k++) begin
        if (state_q == S_CW)
          tiles_d[TW'(ring_tile((k + 1) % RING_LEN))] = tiles_q[TW'(ring_tile(k))];
        else
          tiles_d[TW'(ring_tile(k))] = tiles_q[TW'(ring_tile((k + 1) % RING_LEN))];
      end
    end

    if (state_q == S_IDLE || state_d == S_IDLE) div_d = '0;
    else if (tick)                              div_d = key_hit ? div_q : '0;
    else                                        div_d = div_q + DW'(1);

    cursor_d = TW'(32'(row_d) * COLS + 32'(col_d));
  end

  // Pixel path: tile lookup by boundary compares, syncs and RGB share one register stage.
  always_comb begin
    hx = 32'(HcntValue);
    vy = 32'(VcntValue);
    pc = 0;
    pr = 0;
    for (int unsigned c = 1; c < COLS; c++) if (hx >= H_START + 1 + c * TILE_W) pc = c;
    for (int unsigned r = 1; r < ROWS; r++) if (vy >= V_START + 1 + r * TILE_H) pr = r;
    in_win = (hx > H_START) && (hx <= H_START + ACT_W) && (hx <= H_START + COLS * TILE_W) &&
             (vy > V_START) && (vy <= V_START + ACT_H) && (vy <= V_START + ROWS * TILE_H);
    pix = tiles_q[TW'(pr * COLS + pc)];
`ifdef TILE_CURSOR_EN
    lx = hx - (H_START + 1) - pc * TILE_W;
    ly = vy - (V_START + 1) - pr * TILE_H;
    if (TW'(pr * COLS + pc) == cursor_q &&
        (lx < 2 || lx >= TILE_W - 2 || ly < 2 || ly >= TILE_H - 2))
      pix = ~pix;
`endif
    rgb_d   = in_win ? pix : '0;
    hsync_d = !(hx >= 16 && hx <= 111);
    vsync_d = (vy >= 12 && vy <= 13);
  end

  always_ff @(posedge clk25 or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NT; i++) tiles_q[i] <= '0;
      row_q         <= '0;
      col_q         <= '0;
      cursor_q      <= '0;
      state_q       <= S_IDLE;
      div_q         <= '0;
      loop_active_q <= 1'b0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b0;
      rgb_q         <= '0;
    end else begin
      for (int unsigned i = 0; i < NT; i++) tiles_q[i] <= tiles_d[i];
      row_q         <= row_d;
      col_q         <= col_d;
      cursor_q      <= cursor_d;
      state_q       <= state_d;
      div_q         <= div_d;
      loop_active_q <= (state_d != S_IDLE);
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      rgb_q         <= rgb_d;
    end
  end

  assign hsync              = hsync_q;
  assign vsync              = vsync_q;
  assign {red, green, blue} = rgb_q;
  assign cursor             = cursor_q;
  assign loop_active        = loop_active_q;

endmodule

// File: tb/tb_vga_tile_grid.sv
// Directed bench for vga_tile_grid (3x3 grid, LOOP_DIV=3); honours TILE_CURSOR_EN for highlight expectations.
module tb_vga_tile_grid;

  logic       clk25 = 1'b0;
  logic       reset;
  logic [9:0] h;
  logic [8:0] v;
  logic [7:0] sc;
  logic       found;
  logic       hsync, vsync, la;
  logic [2:0] r, g, b;
  logic [3:0] cur;
  int         tests_run = 0;
  int         tests_failed = 0;

  vga_tile_grid #(.LOOP_DIV(3)) dut (
    .clk25(clk25), .reset(reset), .HcntValue(h), .VcntValue(v),
    .scancode(sc), .found(found), .hsync(hsync), .vsync(vsync),
    .red(r), .green(g), .blue(b), .cursor(cur), .loop_active(la)
  );

  always #20 clk25 = ~clk25;

  task automatic tick();
    @(posedge clk25);
    #1;
  endtask

  task automatic press(input logic [7:0] code);
    sc = code;
    found = 1'b1;
    tick();
    found = 1'b0;
  endtask

  task automatic at(input int hh, input int vv);
    h = 10'(hh);
    v = 9'(vv);
  endtask

  task automatic test_reset();
    reset = 1'b0; found = 1'b0; sc = 8'h00;
    at(200, 100);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    tests_run++; if ({r, g, b} !== 9'd0) begin tests_failed++; $display("FAIL reset_rgb got=%b exp=0", {r, g, b}); end
    tests_run++; if (hsync !== 1'b1) begin tests_failed++; $display("FAIL reset_hsync got=%b exp=1", hsync); end
    tests_run++; if (vsync !== 1'b0) begin tests_failed++; $display("FAIL reset_vsync got=%b exp=0", vsync); end
    tests_run++; if (cur !== 4'd0) begin tests_failed++; $display("FAIL reset_cursor got=%0d exp=0", cur); end
    tests_run++; if (la !== 1'b0) begin tests_failed++; $display("FAIL reset_loop got=%b exp=0", la); end
  endtask

  task automatic test_sync();
    int   hv [8] = '{15, 16, 111, 112, 200, 200, 200, 200};
    int   vv [8] = '{100, 100, 100, 100, 11, 12, 13, 14};
    logic hs [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic vs [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      at(hv[i], vv[i]);
      tick();
      tests_run++;
      if (hsync !== hs[i] || vsync !== vs[i]) begin
        tests_failed++;
        $display("FAIL sync[%0d] h=%0d v=%0d got hs=%b vs=%b exp hs=%b vs=%b", i, hv[i], vv[i], hsync, vsync, hs[i], vs[i]);
      end
    end
  endtask

  task automatic test_cursor_paint();
    press(8'h23); press(8'h23); press(8'h1B); press(8'h2D);
    tests_run++; if (cur !== 4'd5) begin tests_failed++; $display("FAIL cursor5 got=%0d exp=5", cur); end
    at(700, 250); tick();
    tests_run++; if ({r, g, b} !== 9'b111_000_000) begin tests_failed++; $display("FAIL tile5_red got=%b exp=111000000", {r, g, b}); end
    at(500, 250); tick();
    tests_run++; if ({r, g, b} !== 9'd0) begin tests_failed++; $display("FAIL tile4_black got=%b exp=0", {r, g, b}); end
    press(8'h23);
    tests_run++; if (cur !== 4'd5) begin tests_failed++; $display("FAIL sat_right got=%0d exp=5", cur); end
    press(8'h1D); press(8'h1D); press(8'h1D);
    tests_run++; if (cur !== 4'd2) begin tests_failed++; $display("FAIL sat_up got=%0d exp=2", cur); end
    press(8'h1C); press(8'h1C); press(8'h1C); press(8'h5A);
    tests_run++; if (cur !== 4'd0) begin tests_failed++; $display("FAIL sat_left got=%0d exp=0", cur); end
    press(8'h1B); press(8'h1B); press(8'h1B);
    tests_run++; if (cur !== 4'd6) begin tests_failed++; $display("FAIL sat_down got=%0d exp=6", cur); end
  endtask

  task automatic test_boundary();
    press(8'h15); press(8'h2B);
    at(160, 100); tick();
    tests_run++; if ({r, g, b} !== 9'd0) begin tests_failed++; $display("FAIL edge_h160 got=%b exp=0", {r, g, b}); end
    at(161, 100); tick();
    tests_run++; if ({r, g, b} !== 9'h1FF) begin tests_failed++; $display("FAIL edge_h161 got=%b exp=111111111", {r, g, b}); end
    at(161, 48); tick();
    tests_run++; if ({r, g, b} !== 9'd0) begin tests_failed++; $display("FAIL edge_v48 got=%b exp=0", {r, g, b}); end
    at(161, 49); tick();
    tests_run++; if ({r, g, b} !== 9'h1FF) begin tests_failed++; $display("FAIL edge_v49 got=%b exp=111111111", {r, g, b}); end
  endtask

  task automatic test_rotate();
    press(8'h15); press(8'h32); press(8'h4B);
    at(400, 100); repeat (4) tick();
    tests_run++; if (b !== 3'd0) begin tests_failed++; $display("FAIL rot_t1_early got=%0d exp=0", b); end
    tick();
    tests_run++; if (b !== 3'd7) begin tests_failed++; $display("FAIL rot_t1 got=%0d exp=7", b); end
    at(700, 100); repeat (3) tick();
    tests_run++; if (b !== 3'd0) begin tests_failed++; $display("FAIL rot_t2_early got=%0d exp=0", b); end
    tick();
    tests_run++; if (b !== 3'd7) begin tests_failed++; $display("FAIL rot_t2 got=%0d exp=7", b); end
    at(700, 250); repeat (4) tick();
    tests_run++; if (b !== 3'd7) begin tests_failed++; $display("FAIL rot_t5 got=%0d exp=7", b); end
    press(8'h42);
    tests_run++; if (la !== 1'b1) begin tests_failed++; $display("FAIL rot_active got=%b exp=1", la); end
    at(700, 100); repeat (2) tick();
    tests_run++; if (b !== 3'd0) begin tests_failed++; $display("FAIL ccw_early got=%0d exp=0", b); end
    tick();
    tests_run++; if (b !== 3'd7) begin tests_failed++; $display("FAIL ccw_t2 got=%0d exp=7", b); end
  endtask

  task automatic test_collision();
    press(8'h15); press(8'h1B); press(8'h4B);
    repeat (3) tick();
    press(8'h34);
    at(200, 250); tick();
    tests_run++; if (g !== 3'd7) begin tests_failed++; $display("FAIL coll_t3 got=%0d exp=7", g); end
    at(200, 100); tick();
    tests_run++; if (g !== 3'd7) begin tests_failed++; $display("FAIL coll_t0 got=%0d exp=7", g); end
    repeat (3) tick();
    tests_run++; if (g !== 3'd7) begin tests_failed++; $display("FAIL coll_hold got=%0d exp=7", g); end
    tick();
    tests_run++; if (g !== 3'd0) begin tests_failed++; $display("FAIL coll_next got=%0d exp=0", g); end
  endtask

  task automatic test_clear();
    press(8'h2B);
    tick();
    tests_run++; if (la !== 1'b1) begin tests_failed++; $display("FAIL clr_pre got=%b exp=1", la); end
    press(8'h15);
    tests_run++; if (la !== 1'b0) begin tests_failed++; $display("FAIL clr_loop got=%b exp=0", la); end
    tests_run++; if (cur !== 4'd0) begin tests_failed++; $display("FAIL clr_cursor got=%0d exp=0", cur); end
    at(200, 100); repeat (6) tick();
    tests_run++; if ({r, g, b} !== 9'd0) begin tests_failed++; $display("FAIL clr_t0 got=%b exp=0", {r, g, b}); end
    at(200, 250); tick();
    tests_run++; if ({r, g, b} !== 9'd0) begin tests_failed++; $display("FAIL clr_t3 got=%b exp=0", {r, g, b}); end
    at(400, 100); tick();
    tests_run++; if ({r, g, b} !== 9'd0) begin tests_failed++; $display("FAIL clr_t1 got=%b exp=0", {r, g, b}); end
  endtask

  task automatic test_highlight();
    logic [8:0] exp_blk, exp_red;
`ifdef TILE_CURSOR_EN
    exp_blk = 9'h1FF; exp_red = 9'b000_111_111;
`else
    exp_blk = 9'd0;   exp_red = 9'b111_000_000;
`endif
    press(8'h23); press(8'h1B);
    tests_run++; if (cur !== 4'd4) begin tests_failed++; $display("FAIL hl_cursor got=%0d exp=4", cur); end
    at(375, 250); tick();
    tests_run++; if ({r, g, b} !== exp_blk) begin tests_failed++; $display("FAIL hl_border_blk got=%b exp=%b", {r, g, b}, exp_blk); end
    at(480, 250); tick();
    tests_run++; if ({r, g, b} !== 9'd0) begin tests_failed++; $display("FAIL hl_inner_blk got=%b exp=0", {r, g, b}); end
    at(162, 250); tick();
    tests_run++; if ({r, g, b} !== 9'd0) begin tests_failed++; $display("FAIL hl_other got=%b exp=0", {r, g, b}); end
    press(8'h2D);
    at(375, 250); tick();
    tests_run++; if ({r, g, b} !== exp_red) begin tests_failed++; $display("FAIL hl_border_red got=%b exp=%b", {r, g, b}, exp_red); end
    at(480, 250); tick();
    tests_run++; if ({r, g, b} !== 9'b111_000_000) begin tests_failed++; $display("FAIL hl_inner_red got=%b exp=111000000", {r, g, b}); end
  endtask

  task automatic test_reset_mid();
    press(8'h4B);
    at(50, 12); repeat (2) tick();
    tests_run++; if (hsync !== 1'b0 || vsync !== 1'b1 || la !== 1'b1) begin
      tests_failed++; $display("FAIL mid_pre got hs=%b vs=%b la=%b exp 0 1 1", hsync, vsync, la); end
    reset = 1'b0;
    #1;
    tests_run++; if (hsync !== 1'b1 || vsync !== 1'b0 || la !== 1'b0 || cur !== 4'd0) begin
      tests_failed++; $display("FAIL mid_reset got hs=%b vs=%b la=%b cur=%0d exp 1 0 0 0", hsync, vsync, la, cur); end
    tick();
    reset = 1'b1;
    at(480, 250); tick();
    tests_run++; if ({r, g, b} !== 9'd0) begin tests_failed++; $display("FAIL mid_tiles got=%b exp=0", {r, g, b}); end
  endtask

  initial begin
    test_reset();
    test_sync();
    test_cursor_paint();
    test_boundary();
    test_rotate();
    test_collision();
    test_clear();
    test_highlight();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
